// File: rtl/alu_exec_unit.sv
// Multi-cycle integer execution unit: single-cycle add/sub/logic/slt and
// bit-serial shifts. Valid/ready handshakes on the request and result sides.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Neg,
  output logic             Carry,
  output logic             Overflow
);

  // state | meaning
  // IDLE  | waiting for a request, in_ready high
  // SHIFT | shifting one bit position per cycle until the counter expires
  // DONE  | result presented, waiting for out_ready
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  state_t           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] shreg_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             ovf_q;
  logic             out_valid_q;

  logic             is_sub_d;
  logic             is_shift_d;
  logic [SHW-1:0]   shamt_d;
  logic [WIDTH:0]   sum_d;
  logic             add_ovf_d;
  logic             sub_ovf_d;
  logic [WIDTH-1:0] result_d;
  logic             carry_d;
  logic             ovf_d;
  logic [WIDTH-1:0] shift_step_d;

  // slt shares the subtractor, so both use A + ~B + 1
  assign is_sub_d   = (ALUControl == OP_SUB) || (ALUControl == OP_SLT);
  assign is_shift_d = (ALUControl == OP_SLL) || (ALUControl == OP_SRL) ||
                      (ALUControl == OP_SRA);
  assign shamt_d    = SrcB[SHW-1:0];
  assign sum_d      = {1'b0, SrcA} + {1'b0, (is_sub_d ? ~SrcB : SrcB)} +
                      {{WIDTH{1'b0}}, is_sub_d};
  assign add_ovf_d  = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) &&
                      (sum_d[WIDTH-1] != SrcA[WIDTH-1]);
  assign sub_ovf_d  = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) &&
                      (sum_d[WIDTH-1] != SrcA[WIDTH-1]);

  always_comb begin
    result_d = '0;
    carry_d  = 1'b0;
    ovf_d    = 1'b0;
    case (ALUControl)
      OP_ADD: begin
        result_d = sum_d[WIDTH-1:0];
        carry_d  = sum_d[WIDTH];
        ovf_d    = add_ovf_d;
      end
      OP_SUB: begin
        result_d = sum_d[WIDTH-1:0];
        carry_d  = sum_d[WIDTH];
        ovf_d    = sub_ovf_d;
      end
      OP_AND: result_d = SrcA & SrcB;
      OP_OR:  result_d = SrcA | SrcB;
      OP_SLT: result_d = {{(WIDTH-1){1'b0}}, sum_d[WIDTH-1] ^ sub_ovf_d};
      default: result_d = SrcA;  // shifts by zero pass A straight through
    endcase
  end

  always_comb begin
    case (op_q)
      OP_SLL:  shift_step_d = {shreg_q[WIDTH-2:0], 1'b0};
      OP_SRA:  shift_step_d = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
      default: shift_step_d = {1'b0, shreg_q[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q <= ALUControl;
            if (is_shift_d && (shamt_d != '0)) begin
              shreg_q <= SrcA;
              cnt_q   <= shamt_d;
              state_q <= SHIFT;
            end else begin
              result_q    <= result_d;
              carry_q     <= carry_d;
              ovf_q       <= ovf_d;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        SHIFT: begin
          shreg_q <= shift_step_d;
          cnt_q   <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            result_q    <= shift_step_d;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign Result    = result_q;
  assign Zero      = (result_q == '0);
  assign Neg       = result_q[WIDTH-1];
  assign Carry     = carry_q;
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit; expected values are hand-computed.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic        Zero;
  logic        Neg;
  logic        Carry;
  logic        Overflow;

  int total;
  int bad;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Result     (Result),
    .Zero       (Zero),
    .Neg        (Neg),
    .Carry      (Carry),
    .Overflow   (Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {28'd0, Zero, Neg, Carry, Overflow};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE and check latency, result and {Z,N,C,V}.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat,
                        input logic [31:0] exp_res, input logic [3:0] exp_flg);
    int n;
    ALUControl = op;
    SrcA       = a;
    SrcB       = b;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    SrcA     = 32'hDEAD_BEEF;
    SrcB     = 32'hDEAD_BEEF;
    n = 1;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check_val({tag, " lat"}, 32'(n), 32'(exp_lat));
    check_val({tag, " res"}, Result, exp_res);
    check_val({tag, " flg"}, flags(), {28'd0, exp_flg});
    tick();
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    ALUControl = 3'b000;
    SrcA       = '0;
    SrcB       = '0;
    tick();
    tick();
    rst = 1'b0;

    check_val("rst in_ready", 32'(in_ready), 32'd1);
    check_val("rst out_valid", 32'(out_valid), 32'd0);
    check_val("rst result", Result, 32'd0);
    check_val("rst cv", {30'd0, Carry, Overflow}, 32'd0);

    //       tag        op      A             B             lat res           ZNCV
    run_op("add ovf",  3'b000, 32'h7FFFFFFF, 32'h00000001, 1,  32'h80000000, 4'b0101);
    run_op("add wrap", 3'b000, 32'hFFFFFFFF, 32'h00000001, 1,  32'h00000000, 4'b1010);
    run_op("sub eq",   3'b001, 32'd5,        32'd5,        1,  32'h00000000, 4'b1010);
    run_op("sub brw",  3'b001, 32'd0,        32'd1,        1,  32'hFFFFFFFF, 4'b0100);
    run_op("sub vov",  3'b001, 32'h80000000, 32'h00000001, 1,  32'h7FFFFFFF, 4'b0011);
    run_op("slt lt",   3'b101, 32'hFFFFFFFF, 32'h00000001, 1,  32'h00000001, 4'b0000);
    run_op("slt ge",   3'b101, 32'h00000001, 32'hFFFFFFFF, 1,  32'h00000000, 4'b1000);
    run_op("slt ovf",  3'b101, 32'h80000000, 32'h00000001, 1,  32'h00000001, 4'b0000);
    run_op("and",      3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 1,  32'hF000F000, 4'b0100);
    run_op("or",       3'b011, 32'h0000000F, 32'h000000F0, 1,  32'h000000FF, 4'b0000);
    run_op("sra 4",    3'b111, 32'h80000000, 32'd4,        5,  32'hF8000000, 4'b0100);
    run_op("sra pos",  3'b111, 32'h40000000, 32'd3,        4,  32'h08000000, 4'b0000);
    run_op("srl 1",    3'b110, 32'h80000000, 32'd1,        2,  32'h40000000, 4'b0000);
    run_op("srl 0",    3'b110, 32'h12345678, 32'h00000020, 1,  32'h12345678, 4'b0000);
    run_op("sll 31",   3'b100, 32'h00000001, 32'd31,       32, 32'h80000000, 4'b0100);

    // Stall the result for 3 cycles while a second request waits.
    out_ready = 1'b0;
    ALUControl = 3'b000;
    SrcA = 32'd2;
    SrcB = 32'd3;
    in_valid = 1'b1;
    tick();
    ALUControl = 3'b001;
    SrcA = 32'd9;
    SrcB = 32'd3;
    for (int i = 0; i < 3; i++) begin
      check_val("bp valid", 32'(out_valid), 32'd1);
      check_val("bp res", Result, 32'd5);
      check_val("bp flg", flags(), 32'd0);
      check_val("bp ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    check_val("bp held", Result, 32'd5);
    tick();
    check_val("bp idle valid", 32'(out_valid), 32'd0);
    check_val("bp idle ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_val("bp 2nd valid", 32'(out_valid), 32'd1);
    check_val("bp 2nd res", Result, 32'd6);
    check_val("bp 2nd flg", flags(), 32'h2);
    tick();

    // Abort a long shift with reset, then confirm a clean following op.
    ALUControl = 3'b111;
    SrcA = 32'h80000000;
    SrcB = 32'd20;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check_val("abort busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("abort valid", 32'(out_valid), 32'd0);
    check_val("abort res", Result, 32'd0);
    check_val("abort ready", 32'(in_ready), 32'd1);
    check_val("abort flg", {30'd0, Carry, Overflow}, 32'd0);
    run_op("post add", 3'b000, 32'd2, 32'd3, 1, 32'd5, 4'b0000);
    run_op("post sra", 3'b111, 32'h80000000, 32'd2, 3, 32'hE0000000, 4'b0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
